// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding / load-use hazard scoreboard between ID and the ID/EX register.
// Tracks DEPTH in-flight register writes and picks a bypass source per
// ID operand. It raises a load-use stall and keeps a saturating stall counter.

// Per-operand bypass selection: the youngest matching write wins.
module fwd_hazard_lane #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int SEL_W      = 2
) (
  input  logic [DEPTH-1:0]             ent_v,
  input  logic [DEPTH-1:0]             ent_wen,
  input  logic [DEPTH-1:0]             ent_ld,
  input  logic [DEPTH-1:0][REG_AW-1:0] ent_dst,
  input  logic [DEPTH-1:0][DATA_W-1:0] stg_data,
  input  logic [REG_AW-1:0]            src,
  input  logic [DATA_W-1:0]            rf,
  output logic [SEL_W-1:0]             sel,
  output logic [DATA_W-1:0]            data,
  output logic                         hazard
);
  // Scan oldest to youngest so the youngest match overwrites older ones.
  // A match that cannot supply data yet still owns the operand (hazard).
  always_comb begin
    sel    = '0;
    data   = rf;
    hazard = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_v[k] && ent_wen[k] && (ent_dst[k] == src) && (src != '0)) begin
        sel    = SEL_W'(k + 1);
        data   = stg_data[k];
        hazard = ent_ld[k] && (k < LOAD_STAGE);
      end
    end
  end
endmodule

module fwd_hazard_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic                      flush,
  input  logic                      iss_valid,
  input  logic                      iss_wen,
  input  logic [REG_AW-1:0]         iss_dst,
  input  logic                      iss_is_load,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] rf_data,
  input  logic [DEPTH*DATA_W-1:0]   stg_data,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);
  typedef struct packed {
    logic              wen;
    logic [REG_AW-1:0] dst;
    logic              ld;
  } ent_t;

  logic [DEPTH-1:0]             vld_pipe;
  ent_t [DEPTH-1:0]             ent;
  logic [DEPTH-1:0]             ent_wen, ent_ld;
  logic [DEPTH-1:0][REG_AW-1:0] ent_dst;
  logic [DEPTH-1:0][DATA_W-1:0] stg_a;
  logic [NUM_SRC-1:0][REG_AW-1:0] src_a;
  logic [NUM_SRC-1:0][DATA_W-1:0] rf_a, data_a;
  logic [NUM_SRC-1:0][SEL_W-1:0]  sel_a;
  logic [NUM_SRC-1:0]             haz;
  logic                           issue;

  assign stg_a    = stg_data;
  assign src_a    = src_addr;
  assign rf_a     = rf_data;
  assign fwd_sel  = sel_a;
  assign fwd_data = data_a;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    assign ent_wen[k] = ent[k].wen;
    assign ent_ld[k]  = ent[k].ld;
    assign ent_dst[k] = ent[k].dst;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    fwd_hazard_lane #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH),
      .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
    ) u_lane (
      .ent_v   (vld_pipe),
      .ent_wen (ent_wen),
      .ent_ld  (ent_ld),
      .ent_dst (ent_dst),
      .stg_data(stg_a),
      .src     (src_a[i]),
      .rf      (rf_a[i]),
      .sel     (sel_a[i]),
      .data    (data_a[i]),
      .hazard  (haz[i])
    );
  end

  // Flush kills the ID instruction, so it also cancels its stall.
  assign stall = iss_valid && !flush && (|haz);
  assign issue = iss_valid && !stall && !flush;

  // Shift tracked writes down the pipe; hold freezes everything, reset clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      ent       <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        vld_pipe[k] <= vld_pipe[k-1];
        ent[k]      <= ent[k-1];
      end
      vld_pipe[0] <= issue;
      // Bubbles carry zero payload so iss_* are ignored when not issuing.
      ent[0]      <= issue ? ent_t'{wen: iss_wen, dst: iss_dst, ld: iss_is_load} : '0;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed scoreboard bench: expected outputs are queued as each cycle's
// stimulus is driven and compared at the following negedge.
module tb_fwd_hazard_scoreboard;
  localparam int DW = 32, AW = 5, NS = 2, DP = 3, CW = 4;

  logic          clk = 1'b0;
  logic          rst, hold, flush, iss_valid, iss_wen, iss_is_load;
  logic [AW-1:0] iss_dst;
  logic [NS*AW-1:0] src_addr;
  logic [NS*DW-1:0] rf_data;
  logic [DP*DW-1:0] stg_data;
  logic [NS*2-1:0]  fwd_sel;
  logic [NS*DW-1:0] fwd_data;
  logic             stall;
  logic [CW-1:0]    stall_cnt;

  int total = 0, bad = 0;

  typedef struct {
    string       tag;
    logic [1:0]  s0, s1;
    logic [31:0] d0, d1;
    bit          dc0;
    logic        st;
    logic [3:0]  cnt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fwd_hazard_scoreboard #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .DEPTH(DP),
                          .LOAD_STAGE(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_dst(iss_dst),
    .iss_is_load(iss_is_load), .src_addr(src_addr), .rf_data(rf_data),
    .stg_data(stg_data), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .stall(stall), .stall_cnt(stall_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic drv(input bit v, input bit w, input int dst, input bit ld,
                     input int s1, input int s0);
    iss_valid = v; iss_wen = w; iss_dst = AW'(dst); iss_is_load = ld;
    src_addr = {AW'(s1), AW'(s0)};
  endtask

  task automatic push(input string tag, input int s1, input int s0,
                      input logic [31:0] d1, input logic [31:0] d0, input bit dc0,
                      input bit st, input int cnt);
    exp_t e;
    e.tag = tag; e.s1 = 2'(s1); e.s0 = 2'(s0); e.d1 = d1; e.d0 = d0;
    e.dc0 = dc0; e.st = st; e.cnt = 4'(cnt);
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".sel0"}, 32'(fwd_sel[1:0]), 32'(e.s0));
      chk({e.tag, ".sel1"}, 32'(fwd_sel[3:2]), 32'(e.s1));
      if (!e.dc0) chk({e.tag, ".d0"}, fwd_data[31:0], e.d0);
      chk({e.tag, ".d1"}, fwd_data[63:32], e.d1);
      chk({e.tag, ".stall"}, 32'(stall), 32'(e.st));
      chk({e.tag, ".cnt"}, 32'(stall_cnt), 32'(e.cnt));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    drv(0, 0, 0, 0, 2, 1);
    rf_data  = {32'h22, 32'h11};
    stg_data = '0;
    @(posedge clk); #1;
    // reset then idle
    rst = 1'b0;
    push("idle", 0, 0, 32'h22, 32'h11, 0, 0, 0); cyc();
    // ALU back-to-back: add r3, then read it from EX, MEM, WB
    drv(1, 1, 3, 0, 2, 1);
    push("add_r3", 0, 0, 32'h22, 32'h11, 0, 0, 0); cyc();
    drv(0, 0, 0, 0, 2, 3); stg_data = {32'h0, 32'h0, 32'hAAAA};
    push("fwd_ex", 0, 1, 32'h22, 32'hAAAA, 0, 0, 0); cyc();
    stg_data = {32'h0, 32'hBBBB, 32'h0};
    push("fwd_mem", 0, 2, 32'h22, 32'hBBBB, 0, 0, 0); cyc();
    stg_data = {32'hAAAA, 32'h2, 32'h1};
    push("fwd_wb", 0, 3, 32'h22, 32'hAAAA, 0, 0, 0); cyc();
    // load-use: lw r4, then add r6 reading r4
    drv(1, 1, 4, 1, 2, 1);
    push("lw_r4", 0, 0, 32'h22, 32'h11, 0, 0, 0); cyc();
    drv(1, 1, 6, 0, 2, 4); stg_data = {32'h0, 32'h0, 32'hDEAD};
    push("ld_use", 0, 1, 32'h22, 32'h0, 1, 1, 0); cyc();
    stg_data = {32'h0, 32'h1234, 32'h0};
    push("ld_fwd", 0, 2, 32'h22, 32'h1234, 0, 0, 1); cyc();
    // priority and r0: writes r5, r0, r5 in flight
    drv(1, 1, 5, 0, 2, 1);
    push("add_r5a", 0, 0, 32'h22, 32'h11, 0, 0, 1); cyc();
    drv(1, 1, 0, 0, 2, 1);
    push("add_r0", 0, 0, 32'h22, 32'h11, 0, 0, 1); cyc();
    drv(1, 1, 5, 0, 2, 1);
    push("add_r5b", 0, 0, 32'h22, 32'h11, 0, 0, 1); cyc();
    drv(0, 0, 0, 0, 0, 5); stg_data = {32'h52, 32'h51, 32'h50};
    push("prio_r0", 0, 1, 32'h22, 32'h50, 0, 0, 1); cyc();
    // hold/flush interplay around a load-use stall on r7
    drv(0, 0, 0, 0, 2, 1);
    push("drain", 0, 0, 32'h22, 32'h11, 0, 0, 1); cyc();
    drv(1, 1, 7, 1, 2, 1);
    push("lw_r7", 0, 0, 32'h22, 32'h11, 0, 0, 1); cyc();
    drv(1, 1, 8, 0, 2, 7); hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("hold%0d", i), 0, 1, 32'h22, 32'h0, 1, 1, 1); cyc();
    end
    hold = 1'b0; flush = 1'b1;
    push("flush", 0, 1, 32'h22, 32'h0, 1, 0, 1); cyc();
    flush = 1'b0; drv(0, 0, 0, 0, 2, 7); stg_data = {32'h0, 32'h7777, 32'h0};
    push("post_flush", 0, 2, 32'h22, 32'h7777, 0, 0, 1); cyc();
    // saturation: 20 load-use stalls on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drv(1, 1, 9, 1, 2, 1); stg_data = '0;
      push($sformatf("sat_lw%0d", i), 0, 0, 32'h22, 32'h11, 0, 0, (1 + i > 15) ? 15 : 1 + i); cyc();
      drv(1, 1, 10, 0, 2, 9);
      push($sformatf("sat_st%0d", i), 0, 1, 32'h22, 32'h0, 1, 1, (1 + i > 15) ? 15 : 1 + i); cyc();
      stg_data = {32'h0, 32'h900 + 32'(i), 32'h0};
      push($sformatf("sat_fw%0d", i), 0, 2, 32'h22, 32'h900 + 32'(i), 0, 0, (2 + i > 15) ? 15 : 2 + i); cyc();
    end
    drv(0, 0, 0, 0, 2, 1);
    push("sat_end", 0, 0, 32'h22, 32'h11, 0, 0, 15); cyc();
    // reset mid-stream with a valid write in flight; reset beats hold
    drv(1, 1, 11, 0, 2, 1);
    push("add_r11", 0, 0, 32'h22, 32'h11, 0, 0, 15); cyc();
    drv(0, 0, 0, 0, 2, 11); stg_data = {32'h0, 32'h0, 32'hB0B0};
    rst = 1'b1; hold = 1'b1;
    push("pre_rst", 0, 1, 32'h22, 32'hB0B0, 0, 0, 15); cyc();
    rst = 1'b0; hold = 1'b0;
    push("post_rst", 0, 0, 32'h22, 32'h11, 0, 0, 0); cyc();
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the fixed 2-operand ForwardA/B/C operand muxes.
- Tracks every in-flight register write across DEPTH pipeline stages after decode.
- Picks a bypass source for each of NUM_SRC decode-stage operands and raises load-use stall.
- Keeps a saturating stall counter. Sits between decode (ID) and the ID/EX register.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of operand read ports queried by ID.
- DEPTH, 3, number of tracked stages (entry 0 = EX, 1 = MEM, 2 = WB).
- LOAD_STAGE, 1, first entry index whose stg_data carries load data.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  global pipeline freeze (memory wait).
- flush  in  1  kill instruction currently in ID (taken branch/jump).
- iss_valid  in  1  ID holds a valid instruction.
- iss_wen  in  1  ID instruction writes a register.
- iss_dst  in  REG_AW  ID destination register.
- iss_is_load  in  1  ID instruction is a load.
- src_addr  in  NUM_SRC*REG_AW  operand register numbers; operand i = slice i.
- rf_data  in  NUM_SRC*DATA_W  register-file read data per operand.
- stg_data  in  DEPTH*DATA_W  result at the output of stage k; slice k.
- fwd_sel  out  NUM_SRC*SEL_W  0 = regfile, k+1 = stage k; SEL_W = clog2(DEPTH+1).
- fwd_data  out  NUM_SRC*DATA_W  selected operand value.
- stall  out  1  load-use hazard; ID and IF must hold.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: DEPTH entries {v, wen, dst, ld}, plus stall_cnt. No other storage.
- Reset (rst=1 at posedge): all entries v=0, stall_cnt=0. Resulting outputs: fwd_sel=0, fwd_data=rf_data, stall=0.
- Reset mid-operation discards every tracked write; it beats hold and flush.
- Shift rule at posedge, rst=0:
  - hold=1: all entries and stall_cnt keep their values.
  - Else: entry[k+1] <= entry[k] for every k; entry[DEPTH-1] drops out.
  - Entry[0] <= {1, iss_wen, iss_dst, iss_is_load} when iss_valid & ~stall & ~flush; otherwise a bubble (v=0).
- Match, per operand i and entry k: v & wen & dst==src_addr[i] & src_addr[i]!=0. Register 0 never forwards.
- Priority: the youngest matching entry (lowest k) wins. Older matches are ignored.
- Available: ~ld | (k >= LOAD_STAGE).
  - Youngest match available: fwd_sel[i]=k+1, fwd_data[i]=stg_data[k].
  - Youngest match not available: hazard. Still fwd_sel[i]=k+1; the value is don't-care. Never fall back to an older entry or rf_data.
  - No match: fwd_sel[i]=0, fwd_data[i]=rf_data[i].
- stall = OR over operands of hazard, gated by iss_valid & ~flush. Combinational, same cycle.
- fwd_sel, fwd_data and stall are purely combinational from entries and inputs: zero-cycle latency.
- stall_cnt increments at posedge when stall=1 & hold=0 & rst=0. It saturates at 2^CNT_W-1 and never wraps.
- Simultaneous events:
  - stall & flush: flush wins; stall=0 and a bubble is inserted.
  - hold & stall: stall stays asserted; nothing shifts and the counter does not count.
  - WB match (k=DEPTH-1) is forwarded even though the regfile writes the same cycle.
- The block uses no iss_* input when iss_valid=0.

Test Plan:
- Reset then idle: rst=1 one cycle; src_addr={r2,r1}, rf_data={0x22,0x11} → fwd_sel=0, fwd_data={0x22,0x11}, stall=0, stall_cnt=0.
- ALU back-to-back: issue add r3; next cycle src=r3, stg_data[0]=0xAAAA → fwd_sel=1, fwd_data=0xAAAA.
  - Two cycles later: stg_data[2]=0xAAAA → fwd_sel=3, fwd_data=0xAAAA.
- Load-use: issue lw r4, then ID reads r4 → stall=1 for exactly 1 cycle and a bubble is inserted.
  - Next cycle: fwd_sel=2 with stg_data[1]=0x1234 → fwd_data=0x1234; stall_cnt=1.
- Priority and r0: entries hold writes to r5 at k=0 (0x50) and k=2 (0x52) → fwd_sel=1, fwd_data=0x50.
  - A write to r0 in flight with src=r0 → fwd_sel=0, fwd_data=rf_data.
- Hold/flush interplay: hold=1 during a load-use stall for 3 cycles → entries frozen, stall=1, stall_cnt unchanged.
  - Then flush=1 with hold=0 → stall=0, bubble inserted, stall_cnt unchanged.
- Saturation and reset mid-stream: with CNT_W=4, force 20 stall cycles → stall_cnt stays at 15.
  - Then assert rst with entries valid → next cycle all fwd_sel=0, stall_cnt=0.
